// File: rtl/carry_lookahead_pipe.sv
// Two-stage group-carry generator: S1 registers operands plus per-nibble G/P, S2 registers lookahead carries.
// Latency 2 cycles, 1/cycle throughput; 2-entry skid, in_ready falls when both stages hold data and out_ready=0.
module carry_lookahead_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        ci_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        ci,
    output logic        c4,
    output logic        c8,
    output logic        c12,
    output logic        co
);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [3:0]  g;
        logic [3:0]  p;
    } s1_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        c4;
        logic        c8;
        logic        c12;
        logic        co;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid;
    logic out_valid_q;
    logic s2_load;
    logic in_xfer;

    assign s2_load  = s1_valid & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign in_xfer  = in_valid & in_ready;

    always_comb begin
        logic [4:0] nib_sum;
        nib_sum = '0;
        s1_d    = '0;
        s1_d.a  = a_in;
        s1_d.b  = b_in;
        s1_d.ci = ci_in;
        for (int k = 0; k < 4; k++) begin
            nib_sum     = {1'b0, a_in[4*k +: 4]} + {1'b0, b_in[4*k +: 4]};
            s1_d.g[k]   = nib_sum[4];
            s1_d.p[k]   = &(a_in[4*k +: 4] ^ b_in[4*k +: 4]);
        end
    end

    // Every carry is a flat sum-of-products of the S1 G/P terms so no carry waits on another.
    always_comb begin
        logic [3:0] g;
        logic [3:0] p;
        logic       c;
        g       = s1_q.g;
        p       = s1_q.p;
        c       = s1_q.ci;
        s2_d    = '0;
        s2_d.a  = s1_q.a;
        s2_d.b  = s1_q.b;
        s2_d.ci = c;
        s2_d.c4  = g[0] | (p[0] & c);
        s2_d.c8  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        s2_d.c12 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        s2_d.co  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s2_q        <= '0;
        end else begin
            if (s2_load) begin
                out_valid_q <= 1'b1;
                s2_q        <= s2_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign a         = s2_q.a;
    assign b         = s2_q.b;
    assign ci        = s2_q.ci;
    assign c4        = s2_q.c4;
    assign c8        = s2_q.c8;
    assign c12       = s2_q.c12;
    assign co        = s2_q.co;

endmodule

// File: tb/tb_carry_lookahead_pipe.sv
// Bench for carry_lookahead_pipe: directed vector table, backpressure/reset sequences, random traffic vs arithmetic model.
module tb_carry_lookahead_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        ci_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        c4;
    logic        c8;
    logic        c12;
    logic        co;

    carry_lookahead_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .ci_in     (ci_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .c4        (c4),
        .c8        (c8),
        .c12       (c12),
        .co        (co)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
    } op_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [3:0]  exp_c;   // {c4, c8, c12, co}
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    op_t  q[$];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Carry into bit 4k is bit 4k of the plain sum of the operands' low 4k bits plus ci.
    function automatic logic [3:0] ref_carries(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned m;
        int unsigned s;
        logic [3:0]  r;
        r = '0;
        for (int k = 1; k <= 4; k++) begin
            m = (32'd1 << (4 * k)) - 32'd1;
            s = (32'(x) & m) + (32'(y) & m) + 32'(c);
            r[4 - k] = s[4 * k];
        end
        return r;
    endfunction

    function automatic logic [15:0] sel_sum(input logic [15:0] x, input logic [15:0] y, input logic [3:0] cin);
        logic [15:0] s;
        logic [4:0]  t;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            t = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]} + {4'b0, cin[k]};
            s[4*k +: 4] = t[3:0];
        end
        return s;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci);
        logic ok;
        int   guard;
        ok       = 1'b0;
        guard    = 0;
        in_valid = 1'b1;
        a_in     = ta;
        b_in     = tb_v;
        ci_in    = tci;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
    endtask

    // Scoreboard monitor: samples at negedge what the next posedge will transfer.
    initial begin
        op_t         exp;
        op_t         o;
        logic        stall_prev;
        logic [37:0] held;
        logic [16:0] full;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("hold_stable", {out_valid, a, b, ci, c4, c8, c12, co}, held);
                if (out_valid && out_ready) begin
                    n_out++;
                    chk("scoreboard_has_entry", 48'(q.size() > 0), 48'd1);
                    if (q.size() > 0) begin
                        exp = q.pop_front();
                        chk("order_operands", {a, b, ci}, exp);
                        chk("model_carries", {c4, c8, c12, co}, ref_carries(exp.a, exp.b, exp.ci));
                        full = {1'b0, a} + {1'b0, b} + {16'b0, ci};
                        chk("group_select_sum", {co, sel_sum(a, b, {c12, c8, c4, ci})}, full);
                    end
                end
                if (in_valid && in_ready) begin
                    o.a  = a_in;
                    o.b  = b_in;
                    o.ci = ci_in;
                    q.push_back(o);
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_valid, a, b, ci, c4, c8, c12, co};
            end
        end
    end

    vec_t        tbl[8];
    op_t         op1, op2, op3;
    logic [15:0] ov_hist;
    logic        stop;
    int          n0;
    int          lo;

    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 4'b1100};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 4'b1111};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 4'b0001};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 4'b0000};
        tbl[4] = '{16'h0FFF, 16'h0001, 1'b0, 4'b1110};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 4'b1111};
        tbl[6] = '{16'h1234, 16'h4321, 1'b1, 4'b0000};
        tbl[7] = '{16'h00F0, 16'h0010, 1'b1, 4'b0100};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        ci_in     = 1'b0;
        stop      = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_outputs", {a, b, ci, c4, c8, c12, co}, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, one op at a time through an empty pipe.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci);
            @(negedge clk);
            chk("tbl_latency1", out_valid, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("tbl_latency2", out_valid, 1);
            chk("tbl_operands", {a, b, ci}, {tbl[i].a, tbl[i].b, tbl[i].ci});
            chk("tbl_carries", {c4, c8, c12, co}, tbl[i].exp_c);
            @(posedge clk);
            #1;
        end

        // Eight back-to-back ops must emerge on eight consecutive cycles.
        ov_hist = '0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom));
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    ov_hist[c] = out_valid;
                end
            end
        join
        @(posedge clk);
        #1;
        chk("b2b_count", $countones(ov_hist), 8);
        lo = 0;
        while (lo < 16 && !ov_hist[lo]) lo++;
        chk("b2b_contiguous", ov_hist >> lo, 16'h00FF);

        // Backpressure: two accepts fill the pipe, the third waits.
        out_ready = 1'b0;
        n0  = n_out;
        op1 = '{16'h1111, 16'h2222, 1'b0};
        op2 = '{16'hF00F, 16'h0FF1, 1'b1};
        op3 = '{16'h7FFF, 16'h0001, 1'b0};
        send(op1.a, op1.b, op1.ci);
        send(op2.a, op2.b, op2.ci);
        in_valid = 1'b1;
        a_in     = op3.a;
        b_in     = op3.b;
        ci_in    = op3.ci;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", {a, b, ci}, op1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_head_held", {a, b, ci}, op1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(op3.a, op3.b, op3.ci);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_drain_count", n_out - n0, 3);

        // Reset with two ops in flight.
        out_ready = 1'b0;
        send(16'hABCD, 16'h1234, 1'b1);
        send(16'h5555, 16'hAAAA, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {a, b, ci, c4, c8, c12, co}, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        n0 = n_out;
        send(16'h0FF0, 16'h0011, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_carries", {c4, c8, c12, co}, 4'b0110);
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("post_rst_count", n_out - n0, 1);

        // Random traffic with random backpressure, checked by the monitor.
        fork
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 16'($urandom), 1'($urandom));
                end
                stop = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("final_drain_empty", q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
